// File: rtl/io_responder.sv
// io_responder: IN/OUT peripheral with double-dabble 7-segment display and debounced key input
// Define SIGNED_DISPLAY_EN to show out_data as a two's complement value.
module io_responder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SW_WIDTH = 15
) (
    input  logic                Clock,
    input  logic                reset,
    input  logic                in_req,
    input  logic                out_req,
    input  logic [31:0]         out_data,
    input  logic                insert,
    input  logic [SW_WIDTH-1:0] SW,
    output logic [31:0]         in_data,
    output logic                in_ack,
    output logic                out_ack,
    output logic                stall,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1,
    output logic [6:0]          HEX2,
    output logic [6:0]          HEX3,
    output logic [6:0]          HEX4,
    output logic [6:0]          HEX5,
    output logic [6:0]          HEX6,
    output logic [6:0]          HEX7
);
    typedef enum logic [2:0] {IDLE, CONVERT, SHOW, WAIT_PRESS, WAIT_RELEASE} state_t;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [6:0] DASH = 7'h3F;
    localparam logic [6:0] BLANK = 7'h7F;
    state_t state;
    logic [31:0] bin;
    logic [39:0] bcd;
    logic [38:0] bcd_adj;
    logic [4:0] steps;
    logic [DW-1:0] deb;
    logic [7:1] lead;
    logic ovf;
    logic [7:0][6:0] hex, disp;
`ifdef SIGNED_DISPLAY_EN
    logic neg;
`endif

    function automatic logic [6:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 7'h40;
            4'd1: seg = 7'h79;
            4'd2: seg = 7'h24;
            4'd3: seg = 7'h30;
            4'd4: seg = 7'h19;
            4'd5: seg = 7'h12;
            4'd6: seg = 7'h02;
            4'd7: seg = 7'h78;
            4'd8: seg = 7'h00;
            default: seg = 7'h10;
        endcase
    endfunction

    // The top digit never exceeds 4, so it is passed through without adjustment.
    always_comb begin
        bcd_adj = bcd[38:0];
        for (int i = 0; i < 9; i++)
            bcd_adj[4*i+:4] = bcd[4*i+:4] > 4'd4 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end

    always_comb begin
        lead = '0;
        for (int i = 1; i < 8; i++) lead[i] = |(bcd[31:0] >> (4 * i));
`ifdef SIGNED_DISPLAY_EN
        ovf = neg ? |bcd[39:28] : |bcd[39:32];
`else
        ovf = |bcd[39:32];
`endif
        disp[0] = ovf ? DASH : seg(bcd[3:0]);
        for (int i = 1; i < 8; i++)
            disp[i] = ovf ? DASH : lead[i] ? seg(bcd[4*i+:4]) : BLANK;
`ifdef SIGNED_DISPLAY_EN
        if (neg) disp[7] = DASH;
`endif
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state <= IDLE;
            in_data <= '0;
            in_ack <= 1'b0;
            out_ack <= 1'b0;
            deb <= '0;
            bin <= '0;
            bcd <= '0;
            steps <= '0;
            hex <= {8{BLANK}};
`ifdef SIGNED_DISPLAY_EN
            neg <= 1'b0;
`endif
        end else begin
            in_ack <= 1'b0;
            out_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (out_req) begin
`ifdef SIGNED_DISPLAY_EN
                        neg <= out_data[31];
                        bin <= out_data[31] ? -out_data : out_data;
`else
                        bin <= out_data;
`endif
                        bcd <= '0;
                        steps <= '0;
                        state <= CONVERT;
                    end else if (in_req) begin
                        deb <= '0;
                        state <= WAIT_PRESS;
                    end
                end
                CONVERT: begin
                    bcd <= {bcd_adj, bin[31]};
                    bin <= {bin[30:0], 1'b0};
                    steps <= steps + 5'd1;
                    if (steps == 5'd31) state <= SHOW;
                end
                SHOW: begin
                    hex <= disp;
                    out_ack <= 1'b1;
                    state <= IDLE;
                end
                WAIT_PRESS, WAIT_RELEASE: begin
                    // insert is active-low: a press is 0, a release is 1
                    if (insert != (state == WAIT_RELEASE)) deb <= '0;
                    else if (deb == DW'(DEBOUNCE_CYCLES - 1)) begin
                        deb <= '0;
                        if (state == WAIT_PRESS) begin
                            in_data <= 32'(SW);
                            in_ack <= 1'b1;
                            state <= WAIT_RELEASE;
                        end else state <= IDLE;
                    end else deb <= deb + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stall = (in_req | out_req) & ~in_ack & ~out_ack;
    assign HEX0 = hex[0];
    assign HEX1 = hex[1];
    assign HEX2 = hex[2];
    assign HEX3 = hex[3];
    assign HEX4 = hex[4];
    assign HEX5 = hex[5];
    assign HEX6 = hex[6];
    assign HEX7 = hex[7];
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: scoreboard bench for io_responder (OUT display, debounced IN, reset, priority)
module tb_io_responder;
    logic Clock = 0, reset = 0, in_req = 0, out_req = 0, insert = 1;
    logic [31:0] out_data = 0;
    logic [14:0] SW = 0;
    logic [31:0] in_data;
    logic in_ack, out_ack, stall;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, HEX6, HEX7;
    logic [55:0] hex_all;
    logic [55:0] exp_q[$];
    logic [55:0] last_hex;
    int tests = 0, fails = 0;
    localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    io_responder dut (
        .Clock(Clock), .reset(reset), .in_req(in_req), .out_req(out_req), .out_data(out_data),
        .insert(insert), .SW(SW), .in_data(in_data), .in_ack(in_ack), .out_ack(out_ack),
        .stall(stall), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4),
        .HEX5(HEX5), .HEX6(HEX6), .HEX7(HEX7)
    );

    always #5 Clock = ~Clock;
    assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

    function automatic logic [55:0] model(input logic [31:0] v);
        logic [55:0] r;
        longint m;
        logic n;
        n = 1'b0;
        m = longint'(v);
`ifdef SIGNED_DISPLAY_EN
        n = v[31];
        if (n) m = 64'h1_0000_0000 - longint'(v);
`endif
        if ((n && m > 9999999) || m > 99999999) return {8{7'h3F}};
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[7*i+:7] = (i == 0 || m != 0) ? SEG[int'(m % 10)] : 7'h7F;
            m = m / 10;
        end
        if (n) r[55:49] = 7'h3F;
        return r;
    endfunction

    task automatic out_txn(input logic [31:0] v);
        int cyc;
        logic bad_stall;
        logic [55:0] e;
        out_req = 1;
        out_data = v;
        exp_q.push_back(model(v));
        cyc = 0;
        bad_stall = 0;
        @(negedge Clock);
        while (!out_ack && cyc < 40) begin
            if (stall !== 1'b1) bad_stall = 1;
            @(negedge Clock);
            cyc++;
        end
        tests++;
        if (cyc !== 33) begin fails++; $display("FAIL out_latency(%h): got %0d want 33", v, cyc); end
        tests++;
        if (bad_stall) begin fails++; $display("FAIL stall_busy(%h): got low want high", v); end
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL stall_ack(%h): got %b want 0", v, stall); end
        out_req = 0;
        e = exp_q.pop_front();
        tests++;
        if (hex_all !== e) begin fails++; $display("FAIL hex(%h): got %h want %h", v, hex_all, e); end
        last_hex = e;
    endtask

    task automatic wait_in_ack(output int lows);
        lows = 0;
        do begin
            @(negedge Clock);
            lows++;
        end while (!in_ack && lows < 12);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge Clock);
        tests++;
        if (hex_all !== {8{7'h7F}}) begin fails++; $display("FAIL reset_hex: got %h want all 7f", hex_all); end
        tests++;
        if (in_data !== 32'h0) begin fails++; $display("FAIL reset_in_data: got %h want 0", in_data); end
        tests++;
        if ({in_ack, out_ack, stall} !== 3'b000) begin fails++; $display("FAIL reset_acks: got %b want 000", {in_ack, out_ack, stall}); end
        reset = 1;
        @(negedge Clock);
    endtask

    task automatic test_out;
        logic [31:0] vals [12] = '{32'd12345, 32'd0, 32'd100000000, 32'd99999999, 32'd7, 32'hFFFFFFF9,
                                   32'h80000000, 32'hFF676981, 32'hFF676980, 32'h7FFFFFFF, 32'd4096, 32'd10};
        out_txn(32'd12345);
        tests++;
        if (hex_all !== {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}) begin
            fails++; $display("FAIL hex_12345: got %h", hex_all);
        end
        @(negedge Clock);
        tests++;
        if (out_ack !== 1'b0) begin fails++; $display("FAIL out_ack_pulse: got %b want 0", out_ack); end
        out_txn(32'd0);
        tests++;
        if (hex_all !== {{7{7'h7F}}, 7'h40}) begin fails++; $display("FAIL hex_zero: got %h", hex_all); end
        out_txn(32'd100000000);
        tests++;
        if (hex_all !== {8{7'h3F}}) begin fails++; $display("FAIL hex_ovf: got %h", hex_all); end
`ifdef SIGNED_DISPLAY_EN
        out_txn(32'hFFFFFFF9);
        tests++;
        if (HEX7 !== 7'h3F || HEX0 !== 7'h78) begin fails++; $display("FAIL hex_neg7: got %h %h", HEX7, HEX0); end
`endif
        foreach (vals[i]) out_txn(vals[i]);
        repeat (3) out_txn($urandom);
    endtask

    task automatic test_in;
        int lows;
        logic seen;
        SW = 15'h1A2B;
        in_req = 1;
        @(negedge Clock);
        seen = 0;
        insert = 0;
        repeat (2) begin @(negedge Clock); seen |= in_ack; end
        insert = 1;
        repeat (2) begin @(negedge Clock); seen |= in_ack; end
        tests++;
        if (seen) begin fails++; $display("FAIL glitch: got ack want none"); end
        insert = 0;
        wait_in_ack(lows);
        tests++;
        if (lows !== 4) begin fails++; $display("FAIL press_latency: got %0d want 4", lows); end
        tests++;
        if (in_data !== 32'h00001A2B) begin fails++; $display("FAIL in_data1: got %h want 00001a2b", in_data); end
        tests++;
        if (stall !== 1'b0) begin fails++; $display("FAIL in_stall_ack: got %b want 0", stall); end
        in_req = 0;
        @(negedge Clock);
        tests++;
        if (in_ack !== 1'b0) begin fails++; $display("FAIL in_ack_pulse: got %b want 0", in_ack); end
        SW = 15'h7FFF;
        in_req = 1;
        seen = 0;
        repeat (10) begin @(negedge Clock); seen |= in_ack; end
        tests++;
        if (stall !== 1'b1) begin fails++; $display("FAIL held_stall: got %b want 1", stall); end
        insert = 1;
        repeat (6) begin @(negedge Clock); seen |= in_ack; end
        tests++;
        if (seen) begin fails++; $display("FAIL held_press: got ack want none"); end
        insert = 0;
        wait_in_ack(lows);
        tests++;
        if (lows !== 4) begin fails++; $display("FAIL repress_latency: got %0d want 4", lows); end
        tests++;
        if (in_data !== 32'h00007FFF) begin fails++; $display("FAIL in_data2: got %h want 00007fff", in_data); end
        in_req = 0;
        insert = 1;
        repeat (6) @(negedge Clock);
        tests++;
        if (hex_all !== last_hex) begin fails++; $display("FAIL hex_hold: got %h want %h", hex_all, last_hex); end
    endtask

    task automatic test_both;
        int lows;
        SW = 15'h0055;
        in_req = 1;
        out_txn(32'd42);
        @(negedge Clock);
        insert = 0;
        wait_in_ack(lows);
        tests++;
        if (lows !== 4) begin fails++; $display("FAIL both_in_latency: got %0d want 4", lows); end
        tests++;
        if (in_data !== 32'h00000055) begin fails++; $display("FAIL both_in_data: got %h want 00000055", in_data); end
        in_req = 0;
        insert = 1;
        repeat (6) @(negedge Clock);
    endtask

    task automatic test_back_to_back;
        out_txn(32'd11);
        out_txn(32'd222222);
        out_txn(32'd4000000000);
        @(negedge Clock);
    endtask

    task automatic test_reset_mid;
        out_req = 1;
        out_data = 32'd12345678;
        repeat (10) @(negedge Clock);
        out_req = 0;
        reset = 0;
        repeat (2) @(negedge Clock);
        reset = 1;
        tests++;
        if (hex_all !== {8{7'h7F}}) begin fails++; $display("FAIL midreset_hex: got %h want all 7f", hex_all); end
        tests++;
        if (in_data !== 32'h0) begin fails++; $display("FAIL midreset_in_data: got %h want 0", in_data); end
        tests++;
        if ({in_ack, out_ack} !== 2'b00) begin fails++; $display("FAIL midreset_acks: got %b want 00", {in_ack, out_ack}); end
        @(negedge Clock);
        out_txn(32'd31);
    endtask

    initial begin
        test_reset;
        test_out;
        test_in;
        test_both;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
